// File: rtl/mv_store_sched.sv
// mv_store_sched: round-robin collector of per-block motion vectors from NREQ
// search engines, serialised into single-port store writes with end-of-frame signalling.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for frame_start; no grants
// S_RUN  | arbitrating engines, writing in-range results, counting blocks
// S_DONE | one-cycle frame_done; last write visible on the store port
module mv_store_sched #(
    parameter int NREQ         = 4,
    parameter int ADDR_W       = 21,
    parameter int BLK_W        = 12,
    parameter int FRAME_BLOCKS = 1350
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic [ADDR_W-1:0]     frame_base,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [4*NREQ-1:0]     req_mvx,
    input  logic [4*NREQ-1:0]     req_mvy,
    input  logic [BLK_W*NREQ-1:0] req_blk,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [3:0]            mem_mvx,
    output logic [3:0]            mem_mvy,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_range
);

    localparam int PTR_W = $clog2(NREQ);
    localparam logic [BLK_W:0]   FB       = (BLK_W+1)'(FRAME_BLOCKS);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              state, state_nxt;
    logic [PTR_W-1:0]    rr_ptr;
    logic [BLK_W-1:0]    count;
    logic [ADDR_W-1:0]   base;

    logic [2*NREQ-1:0]   valid_dbl;
    logic [NREQ-1:0]     valid_rot;
    logic                found;
    logic [PTR_W-1:0]    gidx;
    logic [PTR_W:0]      scan;
    logic                xfer;
    logic [3:0]          sel_mvx, sel_mvy;
    logic [BLK_W-1:0]    sel_blk;
    logic                in_range;
    logic [BLK_W:0]      count_inc;
    logic                last;

    // Rotate valids so bit 0 is the engine at rr_ptr; the first set bit wins.
    assign valid_dbl = {req_valid, req_valid};
    assign valid_rot = NREQ'(valid_dbl >> rr_ptr);

    always_comb begin
        found = 1'b0;
        gidx  = '0;
        scan  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && valid_rot[k]) begin
                found = 1'b1;
                scan  = {1'b0, rr_ptr} + (PTR_W+1)'(k);
                if (scan >= (PTR_W+1)'(NREQ))
                    scan = scan - (PTR_W+1)'(NREQ);
                gidx  = scan[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        sel_mvx = '0;
        sel_mvy = '0;
        sel_blk = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (gidx == PTR_W'(j)) begin
                sel_mvx = req_mvx[4*j +: 4];
                sel_mvy = req_mvy[4*j +: 4];
                sel_blk = req_blk[BLK_W*j +: BLK_W];
            end
        end
    end

    assign xfer      = (state == S_RUN) && found;
    assign in_range  = ({1'b0, sel_blk} < FB);
    assign count_inc = {1'b0, count} + (BLK_W+1)'(1);
    assign last      = (count_inc == FB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (frame_start) state_nxt = S_RUN;
            S_RUN:   if (xfer && in_range && last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        busy       = (state != S_IDLE);
        frame_done = (state == S_DONE);
        if (xfer)
            req_ready = NREQ'(1) << gidx;
    end

    // Address/data registers hold their last values between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            count     <= '0;
            base      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_mvx   <= '0;
            mem_mvy   <= '0;
            err_range <= 1'b0;
        end else begin
            mem_we    <= xfer && in_range;
            err_range <= xfer && !in_range;
            if (state == S_IDLE && frame_start) begin
                base  <= frame_base;
                count <= '0;
            end
            if (xfer) begin
                rr_ptr <= (gidx == LAST_IDX) ? '0 : gidx + PTR_W'(1);
                if (in_range) begin
                    mem_addr <= base + ADDR_W'(sel_blk);
                    mem_mvx  <= sel_mvx;
                    mem_mvy  <= sel_mvy;
                    count    <= count_inc[BLK_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_mv_store_sched.sv
// Bench for mv_store_sched: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_mv_store_sched;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 21;
    localparam int BLK_W  = 12;
    localparam int FB     = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  frame_start = 1'b0;
    logic [ADDR_W-1:0]     frame_base = '0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [4*NREQ-1:0]     req_mvx = '0;
    logic [4*NREQ-1:0]     req_mvy = '0;
    logic [BLK_W*NREQ-1:0] req_blk = '0;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [3:0]            mem_mvx, mem_mvy;
    logic                  busy, frame_done, err_range;

    int checks = 0;
    int failures = 0;

    mv_store_sched #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .BLK_W(BLK_W), .FRAME_BLOCKS(FB)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_base(frame_base),
        .req_valid(req_valid), .req_ready(req_ready), .req_mvx(req_mvx),
        .req_mvy(req_mvy), .req_blk(req_blk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_mvx(mem_mvx), .mem_mvy(mem_mvy), .busy(busy), .frame_done(frame_done),
        .err_range(err_range)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_eng(input int i, input int blk, input int mvx, input int mvy);
        req_blk[BLK_W*i +: BLK_W] = BLK_W'(blk);
        req_mvx[4*i +: 4]         = 4'(mvx);
        req_mvy[4*i +: 4]         = 4'(mvy);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint all_outs();
        return longint'({req_ready, mem_we, mem_addr, mem_mvx, mem_mvy, busy, frame_done, err_range});
    endfunction

    // Transaction-level model: phase 0 idle, 1 collecting, 2 frame complete.
    int          m_phase, m_ptr, m_count;
    longint      m_base;
    logic        e_we, e_err;
    longint      e_addr;
    int          e_mvx, e_mvy;

    always @(negedge clk) begin
        int g;
        int b;
        logic [NREQ-1:0] e_rdy;
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_count = 0; m_base = 0;
            e_we = 1'b0; e_err = 1'b0; e_addr = 0; e_mvx = 0; e_mvy = 0;
            chk("reset_outputs", all_outs(), 0);
        end else begin
            g = -1;
            if (m_phase == 1)
                for (int k = 0; k < NREQ; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % NREQ])
                        g = (m_ptr + k) % NREQ;
            e_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
            chk("model_req_ready", longint'(req_ready), longint'(e_rdy));
            chk("model_mem_we", longint'(mem_we), longint'(e_we));
            chk("model_mem_addr", longint'(mem_addr), e_addr);
            chk("model_mem_mvx", longint'(mem_mvx), longint'(e_mvx));
            chk("model_mem_mvy", longint'(mem_mvy), longint'(e_mvy));
            chk("model_busy", longint'(busy), longint'(m_phase != 0));
            chk("model_frame_done", longint'(frame_done), longint'(m_phase == 2));
            chk("model_err_range", longint'(err_range), longint'(e_err));

            e_we = 1'b0;
            e_err = 1'b0;
            case (m_phase)
                0: if (frame_start) begin
                    m_base = longint'(frame_base);
                    m_count = 0;
                    m_phase = 1;
                end
                1: if (g >= 0) begin
                    m_ptr = (g + 1) % NREQ;
                    b = int'(req_blk[BLK_W*g +: BLK_W]);
                    if (b < FB) begin
                        e_we = 1'b1;
                        e_addr = (m_base + longint'(b)) % (longint'(1) << ADDR_W);
                        e_mvx = int'(req_mvx[4*g +: 4]);
                        e_mvy = int'(req_mvy[4*g +: 4]);
                        m_count++;
                        if (m_count == FB) m_phase = 2;
                    end else begin
                        e_err = 1'b1;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    initial begin
        // Reset with all engines requesting.
        rst = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_eng(i, i, i, i);
        repeat (3) tick();
        #3 chk("reset_all_zero", all_outs(), 0);
        tick();
        rst = 1'b0;
        repeat (3) begin
            tick();
            #3 chk("idle_no_grant", longint'(req_ready), 0);
        end

        // Arm a frame, then fairness with out-of-range blocks (dropped).
        tick();
        req_valid = '0;
        frame_start = 1'b1;
        frame_base = 21'h01000;
        tick();
        frame_start = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_eng(i, 100, i, i);
        for (int n = 0; n < 8; n++) begin
            #3 chk("fair_grant_all", longint'(req_ready), longint'(1) << (n % 4));
            tick();
        end
        req_valid = 4'b1010;
        for (int n = 0; n < 4; n++) begin
            #3 chk("fair_grant_1_3", longint'(req_ready), (n % 2 == 0) ? 2 : 8);
            if (n == 0) begin
                chk("drop_err_pulse", longint'(err_range), 1);
                chk("drop_no_we", longint'(mem_we), 0);
            end
            tick();
        end

        // Single write.
        req_valid = 4'b0001;
        set_eng(0, 5, 3, 12);
        #3 chk("single_ready", longint'(req_ready), 1);
        tick();
        req_valid = '0;
        #3;
        chk("single_we", longint'(mem_we), 1);
        chk("single_addr", longint'(mem_addr), 'h01005);
        chk("single_mvx", longint'(mem_mvx), 3);
        chk("single_mvy", longint'(mem_mvy), 12);

        // Fill the frame from engine 2; a frame_start mid-frame must be ignored.
        tick();
        req_valid = 4'b0100;
        for (int blk = 0; blk < 6; blk++) begin
            set_eng(2, blk, blk, 15 - blk);
            if (blk == 2) begin
                frame_start = 1'b1;
                frame_base = 21'h55555;
            end
            tick();
            frame_start = 1'b0;
        end
        set_eng(2, FB, 1, 1);
        #3 chk("drop_ready", longint'(req_ready), 4);
        tick();
        set_eng(2, 6, 9, 9);
        #3;
        chk("drop_err", longint'(err_range), 1);
        chk("drop_we", longint'(mem_we), 0);
        chk("drop_not_done", longint'(busy), 1);
        tick();
        req_valid = 4'b1111;
        #3;
        chk("done_pulse", longint'(frame_done), 1);
        chk("done_we", longint'(mem_we), 1);
        chk("done_addr", longint'(mem_addr), 'h01006);
        chk("done_ready", longint'(req_ready), 0);
        tick();
        #3;
        chk("after_done_pulse", longint'(frame_done), 0);
        chk("after_done_busy", longint'(busy), 0);
        chk("after_done_ready", longint'(req_ready), 0);
        tick();
        #3 chk("idle_ready", longint'(req_ready), 0);

        // Address wrap; frame_start coincident with valid grants nothing that cycle.
        tick();
        frame_start = 1'b1;
        frame_base = 21'h1FFFFF;
        #3 chk("start_cycle_no_grant", longint'(req_ready), 0);
        tick();
        frame_start = 1'b0;
        req_valid = 4'b0010;
        set_eng(1, 2, 5, 6);
        #3 chk("wrap_ready", longint'(req_ready), 2);
        tick();
        req_valid = '0;
        #3;
        chk("wrap_we", longint'(mem_we), 1);
        chk("wrap_addr", longint'(mem_addr), 1);

        // Asynchronous reset right after a write lands.
        tick();
        req_valid = 4'b0001;
        set_eng(0, 3, 7, 7);
        tick();
        #1 chk("pre_reset_we", longint'(mem_we), 1);
        #1 rst = 1'b1;
        #1 chk("async_reset_clear", all_outs(), 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        #3;
        chk("post_reset_no_we", longint'(mem_we), 0);
        chk("post_reset_no_grant", longint'(req_ready), 0);

        // Randomized traffic, occasional frame_start and resets.
        for (int n = 0; n < 2000; n++) begin
            tick();
            rst = (n % 700 == 699);
            frame_start = ($urandom_range(0, 9) == 0);
            frame_base = ADDR_W'($urandom);
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++)
                set_eng(i, int'($urandom_range(0, FB + 1)), int'($urandom_range(0, 15)),
                        int'($urandom_range(0, 15)));
        end
        tick();
        rst = 1'b0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
